// File: rtl/scc_pipe_ctrl_if.sv
// Purpose: handshake/control bundle between the SCC pipeline datapath and
//          scc_pipe_ctrl.
// Signals:
//   datapath -> controller: id_valid, id_instr[31:0], ex_valid, ex_is_load,
//                           ex_dest[2:0], br_taken, resume
//   controller -> datapath: pc_en, pc_sel_br, if_id_en, if_id_flush,
//                           id_ex_bubble, halted, stall_cnt, flush_cnt
// Modports: master = datapath side, slave = controller side.
interface scc_pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [31:0]      id_instr;
  logic             ex_valid;
  logic             ex_is_load;
  logic [2:0]       ex_dest;
  logic             br_taken;
  logic             resume;

  logic             pc_en;
  logic             pc_sel_br;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_instr, ex_valid, ex_is_load, ex_dest, br_taken, resume,
    input  pc_en, pc_sel_br, if_id_en, if_id_flush, id_ex_bubble, halted,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_instr, ex_valid, ex_is_load, ex_dest, br_taken, resume,
    output pc_en, pc_sel_br, if_id_en, if_id_flush, id_ex_bubble, halted,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/scc_pipe_ctrl.sv
// Purpose: pipeline controller for the SCC IF->ID->EX datapath. Decodes the
//          register-read set of the IF/ID instruction, detects load-use
//          hazards against EX, and sequences stalls, branch flushes and the
//          HALT drain/resume through fetch/latch/bubble enables. Keeps
//          saturating stall and flush counters.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - scc_pipe_ctrl_if.slave (decode/EX status in, pipeline enables,
//          halted flag and perf counters out)
// Pipeline enables are combinational from state and inputs; counters and
// FSM state are registered.
module scc_pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst,
  scc_pipe_ctrl_if.slave bus
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [DW-1:0]    r_drain;
  logic [DW-1:0]    w_drain_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [2:0] w_ra;
  logic [2:0] w_rb;
  logic [2:0] w_rc;
  logic       w_rd_a;
  logic       w_rd_b;
  logic       w_rd_c;
  logic       w_is_halt;
  logic       w_hazard;
  logic       w_take;
  logic       w_halt_id;

  logic w_pc_en;
  logic w_pc_sel_br;
  logic w_if_id_en;
  logic w_if_id_flush;
  logic w_id_ex_bubble;
  logic w_halted;
  logic w_stall_inc;
  logic w_flush_inc;

  // Immediate/low field bits do not affect hazard detection.
  logic w_unused_instr;
  assign w_unused_instr = ^bus.id_instr[15:0];

  assign w_ra = bus.id_instr[21:19];
  assign w_rb = bus.id_instr[18:16];
  assign w_rc = bus.id_instr[24:22];

  // Register-read set of the instruction in IF/ID.
  always_comb begin
    w_rd_a    = 1'b0;
    w_rd_b    = 1'b0;
    w_rd_c    = 1'b0;
    w_is_halt = 1'b0;
    case (bus.id_instr[31:30])
      2'b00: w_rd_a = (bus.id_instr[29:26] != 4'b0000);
      2'b01: begin
        w_rd_a = 1'b1;
        w_rd_b = (bus.id_instr[29:25] != 5'b10110);
      end
      2'b10: begin
        w_rd_a = 1'b1;
        w_rd_c = bus.id_instr[25];
      end
      default: begin
        w_rd_a    = (bus.id_instr[28:25] == 4'b0010);
        w_is_halt = bus.id_instr[28] & ~bus.id_instr[27];
      end
    endcase
  end

  assign w_hazard = bus.id_valid & bus.ex_valid & bus.ex_is_load &
                    ((w_rd_a & (w_ra == bus.ex_dest)) |
                     (w_rd_b & (w_rb == bus.ex_dest)) |
                     (w_rd_c & (w_rc == bus.ex_dest)));
  assign w_take    = bus.ex_valid & bus.br_taken;
  assign w_halt_id = bus.id_valid & w_is_halt;

  // State register and drain counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Next state and pipeline enables; reset forces a flushed, frozen front end.
  always_comb begin
    w_state_nxt    = r_state;
    w_drain_nxt    = r_drain;
    w_pc_en        = 1'b0;
    w_pc_sel_br    = 1'b0;
    w_if_id_en     = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_bubble = 1'b1;
    w_halted       = 1'b0;
    w_stall_inc    = 1'b0;
    w_flush_inc    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_take) begin
          w_pc_en       = 1'b1;
          w_pc_sel_br   = 1'b1;
          w_if_id_en    = 1'b1;
          w_if_id_flush = 1'b1;
          w_flush_inc   = 1'b1;
        end else if (w_hazard) begin
          w_stall_inc = 1'b1;
        end else if (w_halt_id) begin
          w_drain_nxt = DRAIN_LOAD;
          w_state_nxt = S_DRAIN;
        end else begin
          w_pc_en        = 1'b1;
          w_if_id_en     = 1'b1;
          w_id_ex_bubble = 1'b0;
        end
      end
      S_DRAIN: begin
        // A branch resolving during drain means the HALT was on a wrong path.
        if (w_take) begin
          w_pc_en       = 1'b1;
          w_pc_sel_br   = 1'b1;
          w_if_id_en    = 1'b1;
          w_if_id_flush = 1'b1;
          w_flush_inc   = 1'b1;
          w_drain_nxt   = '0;
          w_state_nxt   = S_RUN;
        end else if (r_drain == '0) begin
          w_state_nxt = S_HALTED;
        end else begin
          w_drain_nxt = r_drain - DW'(1);
        end
      end
      S_HALTED: begin
        w_halted = 1'b1;
        // PC already points past HALT; drop the HALT held in IF/ID.
        if (bus.resume) begin
          w_pc_en       = 1'b1;
          w_if_id_flush = 1'b1;
          w_state_nxt   = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
    if (rst) begin
      w_pc_en        = 1'b0;
      w_pc_sel_br    = 1'b0;
      w_if_id_en     = 1'b0;
      w_if_id_flush  = 1'b1;
      w_id_ex_bubble = 1'b1;
      w_halted       = 1'b0;
      w_stall_inc    = 1'b0;
      w_flush_inc    = 1'b0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.pc_sel_br    = w_pc_sel_br;
  assign bus.if_id_en     = w_if_id_en;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_bubble = w_id_ex_bubble;
  assign bus.halted       = w_halted;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.flush_cnt    = r_flush_cnt;

endmodule
